regfile_wb_queue: RTL and testbench

- Write-side front end for the 32 x 64-bit register file. It is the single producer that drives the regfile write port (rd, rd_data, write_enable).
- Merges results from the ALU and the load unit through valid/ready handshakes into an in-order queue.
- Drains the queue at one regfile write per cycle.
- Provides a two-port forwarding lookup, so decode sees results that are queued but not yet written.

---
 rtl/regfile_wb_queue.sv | 122 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-side front end for the 32 x XLEN register file.
// It merges ALU and load results into an in-order circular queue, drains one
// regfile write per cycle, and forwards the youngest pending value per register.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   flush                    synchronous discard of all pending entries
//   alu_valid/ready/rd/data  ALU result handshake
//   ld_valid/ready/rd/data   load result handshake (older than ALU on a tie)
//   wb_we/wb_rd/wb_data      regfile write port, driven from the queue head
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2   lookup over queued entries
//   count                    number of valid queue entries
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     wb_we,
    output logic [4:0]               wb_rd,
    output logic [XLEN-1:0]          wb_data,
    input  logic [4:0]               fwd_rs1,
    input  logic [4:0]               fwd_rs2,
    output logic                     fwd_hit1,
    output logic [XLEN-1:0]          fwd_data1,
    output logic                     fwd_hit2,
    output logic [XLEN-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;

    logic [CntW-1:0] free;
    logic            ld_en, alu_en;
    logic [CntW-1:0] enq_cnt;
    logic [PtrW-1:0] alu_idx;
    logic [PtrW-1:0] idx;

    // Free space comes from the registered count only: a pop this cycle does
    // not make room for a push this cycle.
    assign free      = CntW'(DEPTH) - count_q;
    assign ld_ready  = !reset && !flush && (free >= CntW'(1));
    assign alu_ready = !reset && !flush && (free >= (ld_valid ? CntW'(2) : CntW'(1)));

    // Writes to x0 complete the handshake but are never queued.
    assign ld_en   = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign alu_en  = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign enq_cnt = CntW'(ld_en) + CntW'(alu_en);
    assign alu_idx = tail_q + PtrW'(ld_en);

    assign wb_we   = (count_q != '0);
    assign wb_rd   = wb_we ? rd_q[head_q] : 5'd0;
    assign wb_data = wb_we ? data_q[head_q] : '0;
    assign count   = count_q;

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if ((fwd_rs1 != 5'd0) && (rd_q[idx] == fwd_rs1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if ((fwd_rs2 != 5'd0) && (rd_q[idx] == fwd_rs2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            // The head write of this cycle still reaches the regfile.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (ld_en) begin
                rd_q[tail_q]   <= ld_rd;
                data_q[tail_q] <= ld_data;
            end
            if (alu_en) begin
                rd_q[alu_idx]   <= alu_rd;
                data_q[alu_idx] <= alu_data;
            end
            tail_q  <= tail_q + PtrW'(enq_cnt);
            head_q  <= head_q + PtrW'(wb_we);
            count_q <= count_q + enq_cnt - CntW'(wb_we);
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_rd, wb_rd, fwd_rs1, fwd_rs2;
    logic [63:0] alu_data, ld_data, wb_data, fwd_data1, fwd_data2;
    logic        wb_we, fwd_hit1, fwd_hit2;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [68:0] wlog[$];   // {rd, data} of every regfile write seen
    logic [68:0] expq[$];

    regfile_wb_queue #(.DEPTH(4), .XLEN(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    // The regfile as seen by the bench: capture each write at the clock edge.
    always @(posedge clk) begin
        if (wb_we) wlog.push_back({wb_rd, wb_data});
    end

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mcount, acc, guard, n;
        logic e_ld, e_alu;
        reset = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = '0;
        fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
        #2;
        alu_valid = 1'b1; ld_valid = 1'b1;
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_count", count, 0);
        check("rst_fwd_hit1", fwd_hit1, 0);
        alu_valid = 1'b0; ld_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("post_rst_alu_ready", alu_ready, 1);
        wlog.delete();

        // Single ALU write x5 = 0x1234.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234; fwd_rs1 = 5'd5;
        step();
        alu_valid = 1'b0;
        check("single_wb_we", wb_we, 1);
        check("single_wb_rd", wb_rd, 5);
        check("single_wb_data", wb_data, 64'h1234);
        check("single_count", count, 1);
        check("single_fwd_hit", fwd_hit1, 1);
        check("single_fwd_data", fwd_data1, 64'h1234);
        step();
        check("single_count_after", count, 0);
        check("single_wb_we_after", wb_we, 0);
        check("single_log_n", wlog.size(), 1);
        if (wlog.size() == 1) check("single_log", wlog[0], {5'd5, 64'h1234});
        wlog.delete();

        // Dual accept: load older than ALU, same rd.
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'hAA;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hBB; fwd_rs1 = 5'd3;
        #1;
        check("dual_ld_ready", ld_ready, 1);
        check("dual_alu_ready", alu_ready, 1);
        check("dual_no_fwd_inflight", fwd_hit1, 0);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        check("dual_count", count, 2);
        check("dual_head", wb_data, 64'hAA);
        check("dual_fwd_young", fwd_data1, 64'hBB);
        step();
        check("dual_count1", count, 1);
        check("dual_head2", wb_data, 64'hBB);
        check("dual_fwd_after_pop", fwd_data1, 64'hBB);
        step();
        check("dual_empty_hit", fwd_hit1, 0);
        check("dual_empty_data", fwd_data1, 0);
        check("dual_log_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("dual_log0", wlog[0], {5'd3, 64'hAA});
            check("dual_log1", wlog[1], {5'd3, 64'hBB});
        end
        wlog.delete();

        // x0 drop.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF; fwd_rs1 = 5'd0;
        #1;
        check("x0_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("x0_count", count, 0);
        check("x0_wb_we", wb_we, 0);
        check("x0_fwd_hit", fwd_hit1, 0);
        step();
        check("x0_log_n", wlog.size(), 0);
        wlog.delete();

        // Backpressure: both sources always valid, sink drains every cycle.
        mcount = 0; acc = 0; n = 0; guard = 0;
        expq.delete();
        ld_valid = 1'b1; alu_valid = 1'b1;
        ld_rd = 5'd1; ld_data = {$urandom, $urandom};
        alu_rd = 5'd16; alu_data = {$urandom, $urandom};
        while (acc < 20 && guard < 100) begin
            guard++;
            e_ld  = (4 - mcount) >= 1;
            e_alu = (4 - mcount) >= 2;
            #1;
            check("bp_ld_ready", ld_ready, e_ld);
            check("bp_alu_ready", alu_ready, e_alu);
            if (e_ld)  expq.push_back({ld_rd, ld_data});
            if (e_alu) expq.push_back({alu_rd, alu_data});
            mcount = mcount + int'(e_ld) + int'(e_alu) - ((mcount != 0) ? 1 : 0);
            acc = acc + int'(e_ld) + int'(e_alu);
            step();
            check("bp_count", count, mcount);
            n++;
            if (e_ld) begin
                ld_rd = 5'(1 + (n % 15)); ld_data = {$urandom, $urandom};
            end
            if (e_alu) begin
                alu_rd = 5'(16 + (n % 15)); alu_data = {$urandom, $urandom};
            end
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        guard = 0;
        while (count !== 3'd0 && guard < 50) begin
            step();
            guard++;
        end
        check("bp_drained", count, 0);
        check("bp_log_n", wlog.size(), expq.size());
        for (int i = 0; i < expq.size() && i < wlog.size(); i++)
            check("bp_log", wlog[i], expq[i]);
        wlog.delete();

        // Flush with 3 entries pending.
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 64'hA1;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hA2;
        step();
        ld_rd = 5'd12; ld_data = 64'hA3;
        alu_rd = 5'd13; alu_data = 64'hA4;
        step();
        check("fl_count3", count, 3);
        ld_valid = 1'b0; alu_rd = 5'd14; alu_data = 64'hA5;
        flush = 1'b1; fwd_rs1 = 5'd12;
        #1;
        check("fl_alu_ready", alu_ready, 0);
        check("fl_ld_ready", ld_ready, 0);
        check("fl_wb_we", wb_we, 1);
        check("fl_wb_data", wb_data, 64'hA2);
        step();
        flush = 1'b0; alu_valid = 1'b0;
        check("fl_count0", count, 0);
        check("fl_wb_we_after", wb_we, 0);
        check("fl_fwd_hit", fwd_hit1, 0);
        check("fl_log_n", wlog.size(), 2);
        if (wlog.size() == 2) check("fl_log1", wlog[1], {5'd11, 64'hA2});
        step();
        check("fl_log_n2", wlog.size(), 2);
        wlog.delete();

        // Asynchronous reset mid-drain with 2 pending.
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 64'hB1;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'hB2;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        check("ar_count2", count, 2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_wb_we", wb_we, 0);
        check("ar_count", count, 0);
        check("ar_ld_ready", ld_ready, 0);
        check("ar_alu_ready", alu_ready, 0);
        step();
        check("ar_log_n", wlog.size(), 0);
        reset = 1'b0;
        #1;
        check("ar_resume_ready", alu_ready, 1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hC1;
        step();
        alu_valid = 1'b0;
        check("ar_resume_wb_rd", wb_rd, 9);
        check("ar_resume_wb_data", wb_data, 64'hC1);
        step();
        check("ar_resume_log_n", wlog.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
